// File: rtl/gray_ctrl_pkg.sv
// gray_ctrl_pkg: shared state encoding, default width and Gray-step helper
package gray_ctrl_pkg;
  localparam int GRAY_W_DEF = 3;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  function automatic logic pop_one(input logic [31:0] x);
    return x != 0 && (x & (x - 1)) == 0;
  endfunction
endpackage

// File: rtl/gray_seq_checker.sv
// gray_seq_checker: flags any illegal transition of the observed Gray counter
module gray_seq_checker
  import gray_ctrl_pkg::*;
#(
  parameter int GRAY_W = GRAY_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              check,
  input  logic [GRAY_W-1:0] gray,
  input  logic              en,
  input  logic              cnt_reset,
  output logic              err
);
  logic [GRAY_W-1:0] prev_gray;
  logic prev_en, prev_clr, bad;
  assign bad = (prev_clr && gray != '0) ||
               (prev_en && !pop_one(32'(gray ^ prev_gray))) ||
               (!prev_clr && !prev_en && gray != prev_gray);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray <= '0;
      prev_en   <= 1'b0;
      prev_clr  <= 1'b0;
      err       <= 1'b0;
    end else begin
      prev_gray <= gray;
      prev_en   <= en;
      prev_clr  <= cnt_reset;
      err       <= clr ? 1'b0 : err | (check & bad);
    end
  end
endmodule

// File: rtl/gray_run_ctrl.sv
// gray_run_ctrl: runs the Gray counter for a commanded number of steps
module gray_run_ctrl
  import gray_ctrl_pkg::*;
#(
  parameter int GRAY_W = GRAY_W_DEF,
  parameter int STEP_W = 8,
  parameter int WRAP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_clear,
  input  logic              pause,
  input  logic              abort,
  output logic              cnt_en,
  output logic              cnt_reset,
  input  logic [GRAY_W-1:0] cnt_gray,
  input  logic              cnt_overflow,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err
);
  state_t state, state_n;
  logic [STEP_W-1:0] remaining;
  logic accept;
  assign cmd_ready = state == IDLE;
  assign accept    = cmd_ready && cmd_valid;
  assign busy      = state == CLEAR || state == RUN;
  assign done      = state == DONE;
  assign cnt_reset = state == CLEAR;
  assign cnt_en    = state == RUN && !pause && !abort;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = !cmd_valid ? IDLE : cmd_clear ? CLEAR : cmd_steps == '0 ? DONE : RUN;
      CLEAR: state_n = (abort || remaining == '0) ? DONE : RUN;
      RUN:   state_n = (abort || (cnt_en && remaining == STEP_W'(1))) ? DONE : RUN;
      DONE:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      wrap_count <= '0;
      aborted    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        remaining  <= cmd_steps;
        wrap_count <= '0;
        aborted    <= 1'b0;
      end else begin
        if (cnt_en && remaining != '0) remaining <= remaining - 1'b1;
        if (busy && abort) aborted <= 1'b1;
        if (busy && cnt_overflow && wrap_count != '1) wrap_count <= wrap_count + 1'b1;
      end
    end
  end
  // DONE is included so the final step, visible one cycle late, is still checked
  gray_seq_checker #(.GRAY_W(GRAY_W)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept),
    .check     (busy || done),
    .gray      (cnt_gray),
    .en        (cnt_en),
    .cnt_reset (cnt_reset),
    .err       (err)
  );
endmodule

// File: tb/tb_gray_run_ctrl.sv
// tb_gray_run_ctrl: scoreboard bench with behavioural Gray counters on two instances
module tb_gray_run_ctrl;
  typedef struct {
    int fe;
    int rk;
    int en;
    int dk;
    int wrap;
    logic ab;
    logic err;
  } res_t;
  res_t q[$];
  int n_assert = 0;
  int n_fail = 0;
  logic clk = 0;
  logic rst_n = 0;
  logic inject = 0;
  logic       a_cmd_valid = 0, a_cmd_clear = 0, a_pause = 0, a_abort = 0;
  logic [7:0] a_cmd_steps = 0;
  logic       a_cmd_ready, a_cnt_en, a_cnt_reset, a_busy, a_done, a_aborted, a_err, a_ovf;
  logic [3:0] a_wrap;
  logic [2:0] a_gray, bin_a = 3'd2;
  logic       b_cmd_valid = 0;
  logic [7:0] b_cmd_steps = 0;
  logic       b_cmd_ready, b_cnt_en, b_cnt_reset, b_busy, b_done, b_aborted, b_err, b_ovf;
  logic [1:0] b_wrap;
  logic [2:0] b_gray, bin_b = 3'd0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_cnt_reset) bin_a <= 3'd0;
    else if (a_cnt_en) bin_a <= (inject && bin_a == 3'd1) ? 3'd3 : bin_a + 3'd1;
    if (b_cnt_reset) bin_b <= 3'd0;
    else if (b_cnt_en) bin_b <= bin_b + 3'd1;
  end
  assign a_gray = bin_a ^ (bin_a >> 1);
  assign a_ovf  = a_cnt_en && bin_a == 3'd7;
  assign b_gray = bin_b ^ (bin_b >> 1);
  assign b_ovf  = b_cnt_en && bin_b == 3'd7;

  gray_run_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_steps(a_cmd_steps), .cmd_clear(a_cmd_clear), .pause(a_pause), .abort(a_abort),
    .cnt_en(a_cnt_en), .cnt_reset(a_cnt_reset), .cnt_gray(a_gray), .cnt_overflow(a_ovf),
    .busy(a_busy), .done(a_done), .aborted(a_aborted), .wrap_count(a_wrap), .err(a_err)
  );

  gray_run_ctrl #(.WRAP_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_steps(b_cmd_steps), .cmd_clear(1'b0), .pause(1'b0), .abort(1'b0),
    .cnt_en(b_cnt_en), .cnt_reset(b_cnt_reset), .cnt_gray(b_gray), .cnt_overflow(b_ovf),
    .busy(b_busy), .done(b_done), .aborted(b_aborted), .wrap_count(b_wrap), .err(b_err)
  );

  task automatic run(input logic [7:0] steps, input logic clr, input int p_at, input int p_len, input int ab_at);
    res_t e, o;
    logic [2:0] b;
    int k;
    e.fe = steps == 0 ? -1 : (clr ? 2 : 1);
    e.rk = clr ? 1 : -1;
    e.ab = ab_at > 0;
    e.en = e.ab ? ab_at - e.fe : int'(steps);
    e.dk = e.ab ? ab_at + 1 : (steps == 0 ? (clr ? 2 : 1) : e.fe + int'(steps) + p_len);
    b = clr ? 3'd0 : bin_a;
    e.wrap = 0;
    for (int i = 0; i < e.en; i++) begin
      if (b == 3'd7 && e.wrap < 15) e.wrap++;
      b = b + 3'd1;
    end
    e.err = inject;
    q.push_back(e);
    o.fe = -1; o.rk = -1; o.en = 0; o.dk = -1;
    @(negedge clk);
    a_cmd_steps = steps; a_cmd_clear = clr; a_cmd_valid = 1;
    #1;
    n_assert++;
    if (a_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_at_accept: got %b expected 1", a_cmd_ready); end
    @(negedge clk);
    a_cmd_valid = 0;
    k = 1;
    while (k <= 600 && o.dk < 0) begin
      a_pause = k >= p_at && k < p_at + p_len;
      a_abort = k == ab_at;
      #1;
      if (a_cnt_en) begin o.en++; if (o.fe < 0) o.fe = k; end
      if (a_cnt_reset && o.rk < 0) o.rk = k;
      if (a_done) o.dk = k;
      else begin @(negedge clk); k++; end
    end
    a_pause = 0; a_abort = 0;
    @(negedge clk);
    #1;
    o.wrap = int'(a_wrap); o.ab = a_aborted; o.err = a_err;
    e = q.pop_front();
    n_assert += 8;
    if (o.dk !== e.dk) begin n_fail++; $display("FAIL done_cycle: got %0d expected %0d", o.dk, e.dk); end
    if (o.fe !== e.fe) begin n_fail++; $display("FAIL first_en_cycle: got %0d expected %0d", o.fe, e.fe); end
    if (o.rk !== e.rk) begin n_fail++; $display("FAIL cnt_reset_cycle: got %0d expected %0d", o.rk, e.rk); end
    if (o.en !== e.en) begin n_fail++; $display("FAIL en_cycles: got %0d expected %0d", o.en, e.en); end
    if (o.wrap !== e.wrap) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", o.wrap, e.wrap); end
    if (o.ab !== e.ab) begin n_fail++; $display("FAIL aborted: got %b expected %b", o.ab, e.ab); end
    if (o.err !== e.err) begin n_fail++; $display("FAIL err: got %b expected %b", o.err, e.err); end
    if (a_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_done: got %b expected 1", a_cmd_ready); end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    #1;
    n_assert += 2;
    if ({a_cmd_ready, a_cnt_en, a_cnt_reset, a_busy, a_done, a_aborted, a_err, a_wrap} !== 11'b10000000000)
      begin n_fail++; $display("FAIL reset_a: got %b expected 10000000000",
        {a_cmd_ready, a_cnt_en, a_cnt_reset, a_busy, a_done, a_aborted, a_err, a_wrap}); end
    if ({b_cmd_ready, b_cnt_en, b_cnt_reset, b_busy, b_done, b_aborted, b_err, b_wrap} !== 9'b100000000)
      begin n_fail++; $display("FAIL reset_b: got %b expected 100000000",
        {b_cmd_ready, b_cnt_en, b_cnt_reset, b_busy, b_done, b_aborted, b_err, b_wrap}); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic();
    run(8'd5, 1'b1, 0, 0, 0);
    run(8'd10, 1'b1, 0, 0, 0);
  endtask

  task automatic test_pause();
    run(8'd6, 1'b0, 3, 3, 0);
  endtask

  task automatic test_abort();
    run(8'd20, 1'b0, 0, 0, 3);
  endtask

  task automatic test_err_and_zero();
    inject = 1;
    run(8'd4, 1'b1, 0, 0, 0);
    inject = 0;
    run(8'd0, 1'b0, 0, 0, 0);
    run(8'd0, 1'b1, 0, 0, 0);
  endtask

  task automatic test_midrun_reset();
    @(negedge clk);
    a_cmd_steps = 8'd20; a_cmd_clear = 0; a_cmd_valid = 1;
    @(negedge clk); a_cmd_valid = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 0;
    #1;
    n_assert++;
    if ({a_cmd_ready, a_cnt_en, a_cnt_reset, a_busy, a_done, a_aborted, a_err, a_wrap} !== 11'b10000000000)
      begin n_fail++; $display("FAIL midrun_reset: got %b expected 10000000000",
        {a_cmd_ready, a_cnt_en, a_cnt_reset, a_busy, a_done, a_aborted, a_err, a_wrap}); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_back_to_back();
    run(8'd3, 1'b0, 0, 0, 0);
    run(8'd9, 1'b0, 0, 0, 0);
  endtask

  task automatic test_wrap_sat();
    int k, w, ens;
    logic [2:0] b;
    b = bin_b; w = 0;
    for (int i = 0; i < 255; i++) begin
      if (b == 3'd7 && w < 3) w++;
      b = b + 3'd1;
    end
    @(negedge clk);
    b_cmd_steps = 8'd255; b_cmd_valid = 1;
    @(negedge clk); b_cmd_valid = 0;
    k = 1; ens = 0;
    #1;
    while (k <= 400 && !b_done) begin
      if (b_cnt_en) ens++;
      @(negedge clk); #1; k++;
    end
    n_assert += 3;
    if (!b_done) begin n_fail++; $display("FAIL sat_done_timeout: got no done expected done within 400"); end
    if (ens !== 255) begin n_fail++; $display("FAIL sat_en_cycles: got %0d expected 255", ens); end
    @(negedge clk); #1;
    if (int'(b_wrap) !== w) begin n_fail++; $display("FAIL sat_wrap_count: got %0d expected %0d", b_wrap, w); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_abort();
    test_err_and_zero();
    test_midrun_reset();
    test_back_to_back();
    test_wrap_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/gray_run_ctrl.md
# gray_run_ctrl

Sequencer for the 3-bit Gray counter. Accepts run commands over a valid/ready handshake and optionally clears the counter first. It then drives the counter's enable for an exact number of steps and honours pause and abort requests. It counts wrap events and checks every observed counter transition for Gray-code legality. It sits between the control/test logic and the counter instance.

## Interface
- GRAY_W, 3: counter width; must match the counter's Output width.
- STEP_W, 8: width of the step-count command field.
- WRAP_W, 4: width of the wrap-event counter (saturating).

- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Cmd_Valid  in  1  command present.
- Cmd_Ready  out  1  controller can accept a command (high only in IDLE).
- Cmd_Steps  in  STEP_W  number of enabled counter cycles to run.
- Cmd_Clear  in  1  clear the counter before running.
- Pause  in  1  hold the counter; no step is consumed while high.
- Abort  in  1  terminate the current run.
- Cnt_En  out  1  to counter En.
- Cnt_Reset  out  1  to counter Reset: synchronous, active-high, one-cycle pulse.
- Cnt_Gray  in  GRAY_W  counter Output.
- Cnt_Overflow  in  1  counter Overflow.
- Busy  out  1  run in progress (CLEAR or RUN).
- Done  out  1  one-cycle pulse at run end.
- Aborted  out  1  last run ended by Abort; valid from Done until the next accept.
- Wrap_Count  out  WRAP_W  Overflow cycles seen in the current/last run.
- Err  out  1  sticky Gray-sequence error for the current/last run.

## Operation
- FSM states and transitions:
  - IDLE: on Cmd_Valid && Cmd_Ready, latch Cmd_Steps into `remaining`, and clear Wrap_Count, Err and Aborted. Next state is CLEAR if Cmd_Clear; otherwise DONE if Cmd_Steps==0, else RUN.
  - CLEAR: Cnt_Reset=1 for exactly this cycle. Next state is DONE if remaining==0, else RUN.
  - RUN: Cnt_En = !Pause && !Abort (combinational from state and inputs). Each cycle with Cnt_En=1 decrements `remaining`. When `remaining` goes 1→0, the next state is DONE.
  - DONE: Done=1 and Cnt_En=0 for one cycle. Next state is IDLE.
- Abort in CLEAR or RUN:
  - Next state is DONE and Aborted is set.
  - Abort overrides Pause and suppresses that cycle's step.
  - When Abort is in CLEAR, the Cnt_Reset pulse still issues.
  - Abort in IDLE or DONE is ignored.
- Wrap counting: every cycle with Busy && Cnt_Overflow increments Wrap_Count. Wrap_Count saturates at 2^WRAP_W−1.
- Gray checker: registers prev_gray, prev_en (=Cnt_En) and prev_clr (=Cnt_Reset). Evaluated each cycle while Busy or in DONE. Err is set when any of these holds:
  - prev_clr and Cnt_Gray≠0;
  - prev_en and popcount(Cnt_Gray^prev_gray)≠1;
  - neither flag set and Cnt_Gray≠prev_gray.
- Err stays set until the next accepted command.
- Arithmetic: `remaining` is unsigned STEP_W wide and never underflows. No command is accepted outside IDLE.

## Timing
- Reset values: state=IDLE, Cmd_Ready=1, Cnt_En=0, Cnt_Reset=0, Busy=0, Done=0, Aborted=0, Wrap_Count=0, Err=0, remaining=0.
- Reset asserted mid-run: all outputs return to their reset values immediately. The counter is not cleared; Cnt_Reset is never driven during Reset.
- Accept to first Cnt_En: 1 cycle without Clear, 2 cycles with Clear.
- Last enabled cycle to Done: Done is high in the following cycle. Cmd_Ready is high in the cycle after Done.
- Zero-step command: Done 1 cycle after accept (2 cycles with Clear). Cnt_En is never asserted.
- Counter latency: the step enabled in cycle t is visible on Cnt_Gray in cycle t+1. The final step is checked in DONE.
- Pause and Abort are sampled with no latency; they act in the same cycle.

## Structure
- Package gray_ctrl_pkg holds:
  - the FSM state enum (IDLE, CLEAR, RUN, DONE);
  - the GRAY_W default;
  - a popcount-equals-one function.
- Sub-module gray_seq_checker contains prev_gray, prev_en and prev_clr, the Err logic, and the sticky clear.
- Top level contains the FSM, `remaining` and Wrap_Count.

## Test plan
- Reset low, then released; command {Steps=5, Clear=1} with a model counter starting at 011 → Cnt_Reset pulse 1 cycle after accept. Cnt_Gray then goes 000,001,011,010,110,111. Done 5 cycles after the first Cnt_En. Err=0, Wrap_Count=0.
- {Steps=10, Clear=1} → exactly 10 Cnt_En cycles. The counter wraps once (100→000), giving Wrap_Count=1.
- {Steps=6}, Pause high for 3 cycles mid-run → 6 Cnt_En cycles total. Done is delayed by 3 cycles. Cnt_Gray holds while paused with no Err.
- Abort in the 3rd RUN cycle of {Steps=20} → Done next cycle, Aborted=1, 2 enabled cycles counted. Cmd_Ready returns the cycle after Done.
- Model counter forced to jump 001→010 during a step → Err=1, held through Done. Err clears on the next accept. {Steps=0} → Done 1 cycle after accept with no Cnt_En.
- Wrap saturation: WRAP_W=2, {Steps=255} → Wrap_Count stops at 3.
